// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline control slice: ALU codes, opcode/funct values and the
// per-instruction control bundle carried through the stage registers.
package mips_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOP = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef struct packed {
        logic [2:0] alu_ctrl;
        logic       alu_src;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       link;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic [4:0] dst;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

    // Bubble: every control low, ALU idle, no destination.
    localparam ctrl_t CTRL_BUBBLE = {ALU_NOP, 9'b0, 5'd0};

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage decoder: control bundle, illegal flag and source-register usage.
// Optional opcodes (ORI, SLTI, BNE, JAL) are only legal when EXT_ISA is non-zero.
module ctrl_decode
    import mips_pkg::*;
#(
    parameter int EXT_ISA = 0
) (
    input  logic [5:0]        i_opcode,
    input  logic [5:0]        i_funct,
    input  logic [4:0]        i_rt,
    input  logic [4:0]        i_rd,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_illegal,
    output logic              o_rs_used,
    output logic              o_rt_used
);

    localparam bit EXT_ON = (EXT_ISA != 0);

    ctrl_t w_ctrl;
    logic  w_illegal;

    always_comb begin
        w_ctrl    = CTRL_BUBBLE;
        w_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.dst       = i_rd;
                case (i_funct)
                    FN_ADD:  w_ctrl.alu_ctrl = ALU_ADD;
                    FN_SUB:  w_ctrl.alu_ctrl = ALU_SUB;
                    FN_AND:  w_ctrl.alu_ctrl = ALU_AND;
                    FN_OR:   w_ctrl.alu_ctrl = ALU_OR;
                    FN_SLT:  w_ctrl.alu_ctrl = ALU_SLT;
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.dst       = i_rt;
                case (i_opcode)
                    OP_ADDI: w_ctrl.alu_ctrl = ALU_ADD;
                    OP_ANDI: w_ctrl.alu_ctrl = ALU_AND;
                    OP_ORI:  w_ctrl.alu_ctrl = ALU_OR;
                    default: w_ctrl.alu_ctrl = ALU_SLT;
                endcase
                if (!EXT_ON && (i_opcode == OP_ORI || i_opcode == OP_SLTI)) begin
                    w_illegal = 1'b1;
                end
            end
            OP_LW: begin
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.alu_ctrl   = ALU_ADD;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.dst        = i_rt;
            end
            OP_SW: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_ctrl  = ALU_ADD;
                w_ctrl.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                w_ctrl.branch    = 1'b1;
                w_ctrl.branch_ne = (i_opcode == OP_BNE);
                w_ctrl.alu_ctrl  = ALU_SUB;
                if (!EXT_ON && i_opcode == OP_BNE) begin
                    w_illegal = 1'b1;
                end
            end
            OP_J: begin
                w_ctrl.jump = 1'b1;
            end
            OP_JAL: begin
                w_ctrl.jump      = 1'b1;
                w_ctrl.link      = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.dst       = LINK_REG;
                w_illegal        = !EXT_ON;
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_ctrl = CTRL_BUBBLE;
        end
        // $zero is never written, so no stage downstream should see a write to it.
        if (w_ctrl.dst == 5'd0) begin
            w_ctrl.reg_write = 1'b0;
        end
    end

    assign o_ctrl    = w_ctrl;
    assign o_illegal = w_illegal;
    assign o_rs_used = !(i_opcode == OP_J || i_opcode == OP_JAL);
    assign o_rt_used = (i_opcode == OP_RTYPE) || (i_opcode == OP_SW) ||
                       (i_opcode == OP_BEQ) || (i_opcode == OP_BNE);

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: ID/EX, EX/MEM and MEM/WB control registers, load-use stall detection,
// flush handling and a saturating illegal-instruction counter.
module pipe_ctrl_unit
    import mips_pkg::*;
#(
    parameter int EXT_ISA = 0,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [5:0]       id_funct,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             flush,
    output logic             stall,
    output logic [2:0]       ex_alu_ctrl,
    output logic             ex_alu_src,
    output logic             ex_branch,
    output logic             ex_branch_ne,
    output logic             ex_jump,
    output logic             ex_link,
    output logic             ex_mem_read,
    output logic             ex_reg_write,
    output logic [4:0]       ex_dst,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic             mem_reg_write,
    output logic [4:0]       mem_dst,
    output logic             wb_reg_write,
    output logic             wb_mem_to_reg,
    output logic [4:0]       wb_dst,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [CTRL_W-1:0] w_dec_raw;
    ctrl_t             w_dec;
    logic              w_illegal;
    logic              w_rs_used;
    logic              w_rt_used;
    logic              w_stall;
    logic              w_accept;
    logic              w_hit_rs;
    logic              w_hit_rt;
    ctrl_t             w_ex_d;

    ctrl_t             r_ex;
    logic              r_mem_mem_read;
    logic              r_mem_mem_write;
    logic              r_mem_mem_to_reg;
    logic              r_mem_reg_write;
    logic [4:0]        r_mem_dst;
    logic              r_wb_reg_write;
    logic              r_wb_mem_to_reg;
    logic [4:0]        r_wb_dst;
    logic [CNT_W-1:0]  r_illegal_cnt;

    ctrl_decode #(
        .EXT_ISA (EXT_ISA)
    ) u_decode (
        .i_opcode  (id_opcode),
        .i_funct   (id_funct),
        .i_rt      (id_rt),
        .i_rd      (id_rd),
        .o_ctrl    (w_dec_raw),
        .o_illegal (w_illegal),
        .o_rs_used (w_rs_used),
        .o_rt_used (w_rt_used)
    );

    assign w_dec = w_dec_raw;

    // Load in EX whose destination feeds the ID instruction: hold one cycle so it can forward.
    assign w_hit_rs = w_rs_used && (r_ex.dst == id_rs);
    assign w_hit_rt = w_rt_used && (r_ex.dst == id_rt);
    assign w_stall  = id_valid && !flush && r_ex.mem_read && (r_ex.dst != 5'd0) &&
                      (w_hit_rs || w_hit_rt);
    assign w_accept = id_valid && !w_stall && !flush;
    assign w_ex_d   = w_accept ? w_dec : CTRL_BUBBLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex             <= CTRL_BUBBLE;
            r_mem_mem_read   <= 1'b0;
            r_mem_mem_write  <= 1'b0;
            r_mem_mem_to_reg <= 1'b0;
            r_mem_reg_write  <= 1'b0;
            r_mem_dst        <= 5'd0;
            r_wb_reg_write   <= 1'b0;
            r_wb_mem_to_reg  <= 1'b0;
            r_wb_dst         <= 5'd0;
        end else begin
            r_ex             <= w_ex_d;
            r_mem_mem_read   <= r_ex.mem_read;
            r_mem_mem_write  <= r_ex.mem_write;
            r_mem_mem_to_reg <= r_ex.mem_to_reg;
            r_mem_reg_write  <= r_ex.reg_write;
            r_mem_dst        <= r_ex.dst;
            r_wb_reg_write   <= r_mem_reg_write;
            r_wb_mem_to_reg  <= r_mem_mem_to_reg;
            r_wb_dst         <= r_mem_dst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal_cnt <= '0;
        end else if (w_accept && w_illegal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
            r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
        end
    end

    assign stall         = w_stall;
    assign ex_alu_ctrl   = r_ex.alu_ctrl;
    assign ex_alu_src    = r_ex.alu_src;
    assign ex_branch     = r_ex.branch;
    assign ex_branch_ne  = r_ex.branch_ne;
    assign ex_jump       = r_ex.jump;
    assign ex_link       = r_ex.link;
    assign ex_mem_read   = r_ex.mem_read;
    assign ex_reg_write  = r_ex.reg_write;
    assign ex_dst        = r_ex.dst;
    assign mem_mem_read  = r_mem_mem_read;
    assign mem_mem_write = r_mem_mem_write;
    assign mem_reg_write = r_mem_reg_write;
    assign mem_dst       = r_mem_dst;
    assign wb_reg_write  = r_wb_reg_write;
    assign wb_mem_to_reg = r_wb_mem_to_reg;
    assign wb_dst        = r_wb_dst;
    assign illegal_cnt   = r_illegal_cnt;

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameter EXT_ISA, default 0: 1 enables ORI, SLTI, BNE and JAL decode; 0 treats those opcodes as illegal.
REQ-002 Parameter CNT_W, default 8: width of the illegal-instruction counter.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 id_valid  in  1  ID-stage instruction is valid.
REQ-006 id_opcode / id_funct  in  6 / 6  instruction fields [31:26] / [5:0].
REQ-007 id_rs / id_rt / id_rd  in  5 / 5 / 5  register specifiers.
REQ-008 flush  in  1  taken branch/jump resolved; kill the instruction in ID.
REQ-009 stall  out  1  combinational load-use stall to PC and IF/ID.
REQ-010 ex_alu_ctrl  out  3  ALU code: ADD 010, SUB 110, AND 000, OR 001, SLT 111, NOP 100.
REQ-011 ex_alu_src / ex_branch / ex_branch_ne / ex_jump / ex_link  out  1 each  EX-stage controls.
REQ-012 ex_mem_read / ex_reg_write  out  1 / 1; ex_dst  out  5  EX-stage hazard/forward info.
REQ-013 mem_mem_read / mem_mem_write / mem_reg_write  out  1 each; mem_dst  out  5.
REQ-014 wb_reg_write / wb_mem_to_reg  out  1 / 1; wb_dst  out  5.
REQ-015 illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.

Function
REQ-016 Decode SHALL be combinational from the ID inputs; results SHALL appear on ex_* one cycle after acceptance, mem_* after two and wb_* after three.
REQ-017 Acceptance SHALL be id_valid & !stall & !flush; a non-accepted cycle loads a bubble (all controls 0, alu_ctrl NOP, dst 0) into ID/EX.
REQ-018 Decode: R-type (funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010) gives reg_write, dst=rd.
REQ-019 Decode: ADDI gives alu_src, ADD, reg_write, dst=rt; ANDI gives alu_src, AND, reg_write, dst=rt.
REQ-020 Decode: LW gives alu_src, ADD, mem_read, mem_to_reg, reg_write, dst=rt; SW gives alu_src, ADD, mem_write.
REQ-021 Decode: BEQ gives branch, SUB; J gives jump, alu NOP.
REQ-022 Decode with EXT_ISA=1: ORI gives alu_src, OR, dst=rt; SLTI gives alu_src, SLT, dst=rt; BNE gives branch, branch_ne, SUB; JAL gives jump, link, reg_write, dst=31.
REQ-023 An unknown opcode or unknown R-type funct SHALL be illegal and decode as a bubble.
REQ-024 Any decode with dst=0 SHALL have reg_write forced to 0.
REQ-025 stall SHALL be 1 iff id_valid & !flush & ex_mem_read & ex_dst!=0 & (ex_dst==id_rs with rs used, or ex_dst==id_rt with rt used).
REQ-026 rs is used by every opcode except J/JAL; rt is used by R-type, SW, BEQ and BNE.
REQ-027 During stall, EX/MEM and MEM/WB SHALL advance and ID/EX SHALL take a bubble, so stall lasts exactly one cycle per load-use pair.
REQ-028 flush and stall together: flush wins, stall is 0 and ID/EX takes a bubble.
REQ-029 flush does not kill EX/MEM or MEM/WB contents.
REQ-030 illegal_cnt SHALL increment by 1 on each accepted illegal instruction and SHALL hold at 2^CNT_W-1.

Reset
REQ-031 rst SHALL asynchronously clear all pipeline registers to the bubble value and illegal_cnt to 0, including mid-stall or mid-flush; stall therefore reads 0 during reset.
REQ-032 The first acceptance after rst deasserts SHALL occur on the next rising edge with id_valid=1.

Structure
REQ-033 ALU codes, opcode/funct constants and the control-bundle packed struct SHALL live in shared package mips_pkg.
REQ-034 Decode SHALL be a sub-module, ctrl_decode (combinational, EXT_ISA parameter); pipe_ctrl_unit holds the stage registers, hazard logic and counter.

Verification
REQ-035 ADD rd=3 accepted at cycle 0 -> ex_alu_ctrl=010 and ex_dst=3 at cycle 1; wb_reg_write=1 and wb_dst=3 at cycle 3.
REQ-036 LW rt=5, then ADD rs=5 -> stall=1 for exactly one cycle and one bubble in ID/EX; the ADD reaches EX one cycle later.
REQ-037 LW rt=0, then ADD rs=0 -> no stall; the LW shows ex_reg_write=0.
REQ-038 flush=1 while an LW-use stall is pending -> stall=0 and ID/EX bubble; the older LW continues to mem_mem_read=1.
REQ-039 EXT_ISA=0 with BNE opcode 000101 x3, CNT_W=2, then 2 more illegals -> illegal_cnt reads 1, 2, 3, 3, 3; all ex_* show bubble.
REQ-040 EXT_ISA=1 with JAL -> ex_jump=1, ex_link=1, ex_dst=31; asserting rst mid-sequence -> all outputs bubble and illegal_cnt=0 immediately.
